mem_access_unit: RTL

// - MEM-stage load/store unit; sits directly downstream of the ex_mem pipeline register.
// - Uses alu_data_mem as the byte address and rs2_data_mem as the store data.
// - Runs a req/ready handshake on a 32-bit word-addressed data bus and returns formatted load data for mem_wb.
// - Asserts mem_stall while an access is in flight; ex_mem and all upstream stages hold while mem_stall=1.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/load_store_align.sv | 68 ++++++
 rtl/mem_access_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared load/store encodings and the MEM-stage access state type.
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module load_store_align
   import rv32i_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wmask,
   output logic        misaligned,
   output logic        illegal,
   output logic [31:0] load_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      wdata      = '0;
      wmask      = '0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            wdata = {4{rs2[7:0]}};
            wmask = 4'b0001 << addr_lo;
         end
         F3_H, F3_HU: begin
            wdata      = {2{rs2[15:0]}};
            wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
            misaligned = addr_lo[0];
         end
         F3_W: begin
            wdata      = rs2;
            wmask      = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
      if (load && store)
         illegal = 1'b1;
   end

   always_comb begin
      case (addr_lo)
         2'd0:    rd_byte = rdata[7:0];
         2'd1:    rd_byte = rdata[15:8];
         2'd2:    rd_byte = rdata[23:16];
         default: rd_byte = rdata[31:24];
      endcase
      rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
         F3_BU:   load_ext = {24'd0, rd_byte};
         F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
         F3_HU:   load_ext = {16'd0, rd_half};
         F3_W:    load_ext = rdata;
         default: load_ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus access per request, pipeline stalled while in flight.
//  state | meaning
//  IDLE  | waiting for a load/store from ex_mem; bad requests pulse misaligned here
//  BUSY  | dbus_req held, waiting for dbus_ready or timeout
//  DONE  | result in load_data_mem, pipeline released for one edge
module mem_access_unit
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_mem,
   input  logic        store_mem,
   input  logic [2:0]  funct3_mem,
   input  logic [31:0] alu_data_mem,
   input  logic [31:0] rs2_data_mem,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_wmask,
   input  logic        dbus_ready,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] load_data_mem,
   output logic        mem_stall,
   output logic        misaligned,
   output logic        bus_err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e  state;
   logic [7:0]  tmo_cnt;
   logic [31:0] al_wdata;
   logic [3:0]  al_wmask;
   logic        al_misaligned;
   logic        al_illegal;
   logic [31:0] al_load_ext;
   logic        req_any;
   logic        req_bad;
   logic        bus_done;

   load_store_align u_align (
      .addr_lo    (alu_data_mem[1:0]),
      .funct3     (funct3_mem),
      .load       (load_mem),
      .store      (store_mem),
      .rs2        (rs2_data_mem),
      .rdata      (dbus_rdata),
      .wdata      (al_wdata),
      .wmask      (al_wmask),
      .misaligned (al_misaligned),
      .illegal    (al_illegal),
      .load_ext   (al_load_ext)
   );

   assign req_any    = load_mem | store_mem;
   assign req_bad    = al_misaligned | al_illegal;
   assign mem_stall  = ((state == IDLE) && req_any && !req_bad) || (state == BUSY);
   assign misaligned = (state == IDLE) && req_any && req_bad;
   // Ready wins over timeout when both land in the last allowed BUSY cycle.
   assign bus_done   = (state == BUSY) && (dbus_ready || (tmo_cnt == TMO_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         tmo_cnt       <= '0;
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_addr     <= '0;
         dbus_wdata    <= '0;
         dbus_wmask    <= '0;
         load_data_mem <= '0;
         bus_err       <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any && !req_bad) begin
                  state      <= BUSY;
                  tmo_cnt    <= '0;
                  dbus_req   <= 1'b1;
                  dbus_we    <= store_mem;
                  dbus_addr  <= {alu_data_mem[31:2], 2'b00};
                  dbus_wdata <= store_mem ? al_wdata : 32'd0;
                  dbus_wmask <= store_mem ? al_wmask : 4'd0;
               end
            end
            BUSY: begin
               if (bus_done) begin
                  state      <= DONE;
                  tmo_cnt    <= '0;
                  dbus_req   <= 1'b0;
                  dbus_we    <= 1'b0;
                  dbus_addr  <= '0;
                  dbus_wdata <= '0;
                  dbus_wmask <= '0;
                  if (dbus_ready) begin
                     load_data_mem <= dbus_we ? 32'd0 : al_load_ext;
                  end else begin
                     load_data_mem <= '0;
                     bus_err       <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
